encoder8_3_drain: RTL and testbench
===================================

Name: encoder8_3_drain

Overview:
- Sequential 8-to-3 encoder: the inverse of the 3-to-8 decoder path.
- Captures an 8-bit request vector into a pending register.
- Emits the 3-bit index of each set bit, one per accepted transfer, over a valid/ready handshake.
- Sits between request sources (flags, interrupt lines) and a consumer that needs binary indices, e.g. to drive decoder select inputs.

Parameters:
- LSB_FIRST, 1: 1 = lowest set bit index served first; 0 = highest set bit index served first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; sampled only when load=1.
- load  input  1  when 1 at a rising edge, req is ORed into pending.
- out_idx  output  3  binary index of the presented request; registered.
- out_valid  output  1  out_idx is valid; registered.
- out_ready  input  1  consumer accepts; a transfer (fire) = out_valid & out_ready at a rising edge.
- pending  output  8  current pending register (observability).
- drained  output  1  one-cycle pulse when the last pending bit is accepted and nothing new is loaded.

Behaviour:
- Reset (rst=1 at edge):
  - pending=8'h00, out_valid=0, out_idx=3'd0, drained=0.
  - rst dominates load and fire in the same cycle.
  - Reset mid-drain discards all outstanding requests. out_valid is low the cycle after the reset edge.
- Definitions:
  - fire = out_valid & out_ready.
  - clr = fire ? onehot(out_idx) : 8'h00.
  - rem = pending & ~clr.
- Pending update each edge: pending <= rem | (load ? req : 8'h00).
  - A req bit that is set at the moment its index fires is re-set, and is served again later.
  - Bits already pending are unaffected by load (OR semantics, no duplicates).
- Output register update, only when (!out_valid | fire):
  - out_valid <= |rem.
  - out_idx <= priority_encode(rem), direction per LSB_FIRST.
  - When rem==0, out_idx holds its previous value.
  - While out_valid=1 and out_ready=0, out_valid and out_idx hold stable. Newly loaded bits never change the presented index.
- Latency: load at edge t makes pending visible after t; out_valid is first asserted after edge t+1 (2 cycles from load to valid).
- Throughput: with out_ready held 1, one index per cycle, with no bubble between indices.
- Priority is recomputed from rem at each fire edge, so a higher-priority bit loaded later is served before older lower-priority bits. There is no age ordering.
- drained <= fire & (rem==0) & !(load & |req). It is high for exactly one cycle.
- Empty case: pending=0 and load=0 means out_valid stays 0. out_ready is ignored when out_valid=0.
- load with req=8'h00 is a no-op.
- State machine (derived from out_valid):
  - IDLE (out_valid=0): goes to PRESENT when pending != 0.
  - PRESENT (out_valid=1): on fire, goes to IDLE if rem==0, otherwise stays in PRESENT with the next index.
- Any out_idx value 0..7 is legal. There is no invalid-input case: multi-hot req is the normal operating mode.

Test Plan:
- Reset then single load, req=8'b0010_0100, LSB_FIRST=1, out_ready=1:
  - out_valid rises 2 cycles after load.
  - out_idx sequence is 2 then 5 on consecutive cycles.
  - drained pulses on the fire of idx 5; pending=8'h00 after.
- Backpressure: req=8'h81, out_ready=0 for 5 cycles, then 1:
  - out_idx=0 is held stable with out_valid=1 throughout the stall.
  - Then idx 0, then idx 7; exactly one fire per index.
- LSB_FIRST=0, req=8'hFF, out_ready=1: 8 consecutive valid cycles with out_idx 7,6,5,...,0, drained on the last.
- Reload during drain: req=8'h01 loaded, then req=8'h01 loaded again on the same edge idx 0 fires:
  - idx 0 is presented a second time.
  - drained fires only after the second accept.
- Late high-priority arrival (LSB_FIRST=1): req=8'h80 presented and stalled; then load req=8'h02; then out_ready=1:
  - idx 7 fires first (it is already presented).
  - idx 1 fires next.
- Reset mid-operation: req=8'hF0, after the first fire assert rst for 1 cycle:
  - pending=0, out_valid=0 next cycle, drained=0.
  - No further indices are emitted without a new load.

Source files
------------

// File: rtl/encoder8_3_drain_if.sv
// Request/index handshake bundle for encoder8_3_drain.
// The slave side is the encoder; the master side is the surrounding logic or bench.
interface encoder8_3_drain_if;
  logic [7:0] req;
  logic       load;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       drained;

  modport slave (
    input  req, load, out_ready,
    output out_idx, out_valid, pending, drained
  );

  modport master (
    output req, load, out_ready,
    input  out_idx, out_valid, pending, drained
  );
endinterface

// File: rtl/encoder8_3_drain.sv
// Sequential 8-to-3 encoder: accumulates request bits and drains them one
// binary index per accepted transfer over a valid/ready handshake.
module encoder8_3_drain #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  encoder8_3_drain_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] idx_q, idx_d;
  logic       drained_q, drained_d;

  logic       fire;
  logic       advance;
  logic [7:0] clr;
  logic [7:0] rem;
  logic [7:0] load_vec;
  logic [2:0] pe_idx;

  assign fire     = (state_q == PRESENT) & bus.out_ready;
  assign clr      = fire ? (8'h01 << idx_q) : 8'h00;
  assign rem      = pending_q & ~clr;
  assign load_vec = bus.load ? bus.req : 8'h00;
  // The output register may only move when nothing is presented or it is being taken.
  assign advance  = (state_q == IDLE) | fire;

  // Priority encode over rem only, so bits loaded this edge wait a cycle.
  always_comb begin
    pe_idx = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--)
        if (rem[i]) pe_idx = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++)
        if (rem[i]) pe_idx = 3'(i);
    end
  end

  always_comb begin
    pending_d = rem | load_vec;
    state_d   = state_q;
    idx_d     = idx_q;
    if (advance) begin
      state_d = (rem != 8'h00) ? PRESENT : IDLE;
      if (rem != 8'h00) idx_d = pe_idx;
    end
    drained_d = fire & (rem == 8'h00) & ~(bus.load & (|bus.req));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      idx_q     <= 3'd0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      drained_q <= drained_d;
    end
  end

  assign bus.out_valid = (state_q == PRESENT);
  assign bus.out_idx   = idx_q;
  assign bus.pending   = pending_q;
  assign bus.drained   = drained_q;

endmodule

// File: tb/tb_encoder8_3_drain.sv
// Directed bench for encoder8_3_drain: one LSB-first and one MSB-first instance.
module tb_encoder8_3_drain;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  encoder8_3_drain_if lsb_if ();
  encoder8_3_drain_if msb_if ();

  encoder8_3_drain #(.LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(lsb_if));
  encoder8_3_drain #(.LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(msb_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples both sit 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lsb(input string tag, input logic v, input logic [2:0] idx,
                         input logic [7:0] pend, input logic dr);
    chk({tag, ".valid"},   {31'd0, lsb_if.out_valid}, {31'd0, v});
    if (v) chk({tag, ".idx"}, {29'd0, lsb_if.out_idx}, {29'd0, idx});
    chk({tag, ".pending"}, {24'd0, lsb_if.pending},   {24'd0, pend});
    chk({tag, ".drained"}, {31'd0, lsb_if.drained},   {31'd0, dr});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    lsb_if.req = 8'h00; lsb_if.load = 1'b0; lsb_if.out_ready = 1'b0;
    msb_if.req = 8'h00; msb_if.load = 1'b0; msb_if.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.idx", {29'd0, lsb_if.out_idx}, 32'd0);
    chk_lsb("rst", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("rst.msb_valid", {31'd0, msb_if.out_valid}, 32'd0);

    // Empty load is a no-op; ready ignored while invalid
    lsb_if.load = 1'b1; lsb_if.req = 8'h00; lsb_if.out_ready = 1'b1;
    tick();
    lsb_if.load = 1'b0;
    tick();
    chk_lsb("empty", 1'b0, 3'd0, 8'h00, 1'b0);

    // Single load 0010_0100, ready held high
    lsb_if.load = 1'b1; lsb_if.req = 8'b0010_0100;
    tick();
    lsb_if.load = 1'b0;
    chk_lsb("t1.load", 1'b0, 3'd0, 8'h24, 1'b0);
    tick();
    chk_lsb("t1.i2", 1'b1, 3'd2, 8'h24, 1'b0);
    tick();
    chk_lsb("t1.i5", 1'b1, 3'd5, 8'h20, 1'b0);
    tick();
    chk_lsb("t1.done", 1'b0, 3'd0, 8'h00, 1'b1);
    chk("t1.idx_hold", {29'd0, lsb_if.out_idx}, 32'd5);
    tick();
    chk_lsb("t1.pulse", 1'b0, 3'd0, 8'h00, 1'b0);

    // Backpressure on 8'h81
    lsb_if.out_ready = 1'b0;
    lsb_if.load = 1'b1; lsb_if.req = 8'h81;
    tick();
    lsb_if.load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_lsb("t2.stall", 1'b1, 3'd0, 8'h81, 1'b0);
    end
    lsb_if.out_ready = 1'b1;
    tick();
    chk_lsb("t2.i7", 1'b1, 3'd7, 8'h80, 1'b0);
    tick();
    chk_lsb("t2.done", 1'b0, 3'd0, 8'h00, 1'b1);

    // MSB-first drain of 8'hFF
    msb_if.out_ready = 1'b1;
    msb_if.load = 1'b1; msb_if.req = 8'hFF;
    tick();
    msb_if.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t3.valid",   {31'd0, msb_if.out_valid}, 32'd1);
      chk("t3.idx",     {29'd0, msb_if.out_idx},   32'(7 - k));
      chk("t3.drained", {31'd0, msb_if.drained},   32'd0);
    end
    tick();
    chk("t3.end_valid",   {31'd0, msb_if.out_valid}, 32'd0);
    chk("t3.end_drained", {31'd0, msb_if.drained},   32'd1);
    chk("t3.end_pending", {24'd0, msb_if.pending},   32'd0);

    // Reload the same bit on the edge it fires
    lsb_if.load = 1'b1; lsb_if.req = 8'h01;
    tick();
    lsb_if.load = 1'b0;
    tick();
    chk_lsb("t4.first", 1'b1, 3'd0, 8'h01, 1'b0);
    lsb_if.load = 1'b1; lsb_if.req = 8'h01;
    tick();
    lsb_if.load = 1'b0;
    chk_lsb("t4.refire", 1'b0, 3'd0, 8'h01, 1'b0);
    tick();
    chk_lsb("t4.second", 1'b1, 3'd0, 8'h01, 1'b0);
    tick();
    chk_lsb("t4.done", 1'b0, 3'd0, 8'h00, 1'b1);

    // Late higher-priority arrival while idx 7 is stalled
    lsb_if.out_ready = 1'b0;
    lsb_if.load = 1'b1; lsb_if.req = 8'h80;
    tick();
    lsb_if.load = 1'b0;
    tick();
    chk_lsb("t5.pres7", 1'b1, 3'd7, 8'h80, 1'b0);
    lsb_if.load = 1'b1; lsb_if.req = 8'h02;
    tick();
    lsb_if.load = 1'b0;
    chk_lsb("t5.hold7", 1'b1, 3'd7, 8'h82, 1'b0);
    lsb_if.out_ready = 1'b1;
    tick();
    chk_lsb("t5.i1", 1'b1, 3'd1, 8'h02, 1'b0);
    tick();
    chk_lsb("t5.done", 1'b0, 3'd0, 8'h00, 1'b1);

    // Reset mid-drain discards outstanding requests
    lsb_if.load = 1'b1; lsb_if.req = 8'hF0;
    tick();
    lsb_if.load = 1'b0;
    tick();
    chk_lsb("t6.i4", 1'b1, 3'd4, 8'hF0, 1'b0);
    tick();
    chk_lsb("t6.i5", 1'b1, 3'd5, 8'hE0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_lsb("t6.rst", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("t6.rst_idx", {29'd0, lsb_if.out_idx}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_lsb("t6.quiet", 1'b0, 3'd0, 8'h00, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
